// File: rtl/fifo_btn_ctrl_pkg.sv
// Shared types for the button-driven FIFO sequencer: FSM state encoding and
// round-robin grant identifiers.
package fifo_btn_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2,
        StHold = 2'd3
    } state_e;

    typedef enum logic {
        GrantWr = 1'b0,
        GrantRd = 1'b1
    } grant_e;

    // State that services a given grant; used when re-entering from HOLD.
    function automatic state_e grant_state(grant_e g);
        return (g == GrantWr) ? StWr : StRd;
    endfunction

endpackage

// File: rtl/fifo_btn_ctrl_if.sv
// Bundle of button, switch, FIFO and LED signals around the sequencer.
// master = the controller, slave = the surrounding board/FIFO logic.
interface fifo_btn_ctrl_if #(
    parameter int unsigned W = 8
);
    logic         db_wr;
    logic         db_rd;
    logic [W-1:0] sw_data;
    logic         fifo_full;
    logic         fifo_empty;
    logic [W-1:0] fifo_rd_data;
    logic         fifo_wr;
    logic         fifo_rd;
    logic [W-1:0] fifo_wr_data;
    logic [W-1:0] led_data;
    logic         err_full;
    logic         err_empty;
    logic [1:0]   state_cur;

    modport master (
        input  db_wr, db_rd, sw_data, fifo_full, fifo_empty, fifo_rd_data,
        output fifo_wr, fifo_rd, fifo_wr_data, led_data, err_full, err_empty, state_cur
    );

    modport slave (
        output db_wr, db_rd, sw_data, fifo_full, fifo_empty, fifo_rd_data,
        input  fifo_wr, fifo_rd, fifo_wr_data, led_data, err_full, err_empty, state_cur
    );
endinterface

// File: rtl/fifo_btn_ctrl_edge_det.sv
// Rising-edge detector. The history register resets to RST_VAL so a level
// already high when reset releases can be treated as "seen" and not fire.
module fifo_btn_ctrl_edge_det #(
    parameter bit RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);
    logic level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= RST_VAL;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
endmodule

// File: rtl/fifo_btn_ctrl.sv
// Turns debounced button levels into single-cycle FIFO write/read strobes,
// with full/empty gating, round-robin tie break and optional auto-repeat.
module fifo_btn_ctrl
    import fifo_btn_ctrl_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter bit          REP_EN = 1'b0,
    parameter int unsigned REP_N  = 4
) (
    input logic             clk,
    input logic             reset,
    fifo_btn_ctrl_if.master bus
);
    state_e             state_q, state_d;
    grant_e             last_q, last_d;
    logic [REP_N-1:0]   rep_q, rep_d;
    logic [W-1:0]       wr_data_q, wr_data_d;
    logic [W-1:0]       led_q, led_d;
    logic               wr_rise, rd_rise;
    logic               held;

    fifo_btn_ctrl_edge_det #(.RST_VAL(1'b1)) u_wr_edge (
        .clk   (clk),
        .reset (reset),
        .level (bus.db_wr),
        .rise  (wr_rise)
    );

    fifo_btn_ctrl_edge_det #(.RST_VAL(1'b1)) u_rd_edge (
        .clk   (clk),
        .reset (reset),
        .level (bus.db_rd),
        .rise  (rd_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            last_q    <= GrantRd;
            rep_q     <= '0;
            wr_data_q <= '0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rep_q     <= rep_d;
            wr_data_q <= wr_data_d;
            led_q     <= led_d;
        end
    end

    assign held = (last_q == GrantWr) ? bus.db_wr : bus.db_rd;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        rep_d     = rep_q;
        wr_data_d = wr_data_q;
        led_d     = led_q;
        unique case (state_q)
            StIdle: begin
                // Tie goes to the side that did not win last; loser is dropped.
                if ((wr_rise && rd_rise && last_q == GrantRd) || (wr_rise && !rd_rise)) begin
                    state_d   = StWr;
                    wr_data_d = bus.sw_data;
                end else if (rd_rise) begin
                    state_d = StRd;
                end
            end
            StWr: begin
                last_d  = GrantWr;
                rep_d   = '0;
                state_d = StHold;
            end
            StRd: begin
                last_d  = GrantRd;
                rep_d   = '0;
                if (!bus.fifo_empty) begin
                    led_d = bus.fifo_rd_data;
                end
                state_d = StHold;
            end
            StHold: begin
                if (!held) begin
                    state_d = StIdle;
                end else if (REP_EN && (rep_q == '1)) begin
                    state_d = grant_state(last_q);
                    if (last_q == GrantWr) begin
                        wr_data_d = bus.sw_data;
                    end
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign bus.fifo_wr      = (state_q == StWr) & ~bus.fifo_full;
    assign bus.err_full     = (state_q == StWr) &  bus.fifo_full;
    assign bus.fifo_rd      = (state_q == StRd) & ~bus.fifo_empty;
    assign bus.err_empty    = (state_q == StRd) &  bus.fifo_empty;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.led_data     = led_q;
    assign bus.state_cur    = state_q;
endmodule
